// File: rtl/bcd_pkg.sv
// Shared constants for the BCD serial adder slice: digit geometry and FSM encodings.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  // Legacy-compatible state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // True when a 4-bit code is not a legal BCD digit
  function automatic logic digit_bad(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/one_digit_BCD_adder.sv
// Single-digit BCD adder: S/C = A + B + Cin with decimal correction.
// Non-BCD inputs still produce a deterministic (but meaningless) result.
module one_digit_BCD_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       C
);

  logic [4:0] bin_sum;

  // Binary add, then add 6 when the result passes 9 to wrap into the next decade
  always_comb begin
    bin_sum = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
    if (bin_sum > 5'd9) begin
      S = bin_sum[3:0] + 4'd6;
      C = 1'b1;
    end else begin
      S = bin_sum[3:0];
      C = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial BCD adder: one shared digit adder, LSD first, carry rippled through a register.
// valid/ready on both sides; no overlap between result hold and next operand accept.
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] sum,
  output logic                      cout,
  output logic                      err,
  output logic                      busy
);

  localparam int unsigned W  = DIGIT_W * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  sum_reg;
  logic          err_reg;
  logic          in_bad;
  logic [3:0]    dig_a;
  logic [3:0]    dig_b;
  logic [3:0]    dig_s;
  logic          dig_c;

  // Flag any non-BCD digit on either incoming operand
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (digit_bad(a[i*DIGIT_W +: DIGIT_W]) || digit_bad(b[i*DIGIT_W +: DIGIT_W])) begin
        in_bad = 1'b1;
      end
    end
  end

  // Select the current digit pair for the shared adder
  always_comb begin
    dig_a = a_reg[DIGIT_W*int'(cnt) +: DIGIT_W];
    dig_b = b_reg[DIGIT_W*int'(cnt) +: DIGIT_W];
  end

  one_digit_BCD_adder u_digit (
    .A   (dig_a),
    .B   (dig_b),
    .Cin (carry),
    .S   (dig_s),
    .C   (dig_c)
  );

  // FSM, digit counter, carry ripple and digit-enabled sum registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= b;
            carry   <= cin;
            cnt     <= '0;
            err_reg <= in_bad;
            state   <= ST_ADD;
          end
        end
        ST_ADD: begin
          carry <= dig_c;
          for (int i = 0; i < int'(DIGITS); i++) begin
            if (cnt == CW'(i)) sum_reg[i*DIGIT_W +: DIGIT_W] <= dig_s;
          end
          if (cnt == CNT_LAST) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state == ST_ADD) || (state == ST_DONE);
    sum       = sum_reg;
    cout      = out_valid & carry;
    err       = err_reg;
  end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Scoreboard bench for bcd_serial_adder_ctrl: random BCD ops checked against decimal arithmetic.
module tb_bcd_serial_adder_ctrl;

  localparam int unsigned D = 4;
  localparam int unsigned W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, err, busy;
  logic [W-1:0] a, b, sum;

  // DIGITS=1 instance
  logic       in_valid1, in_ready1, cin1, out_valid1, cout1, err1, busy1;
  logic [3:0] a1, b1, sum1;

  always #5 clk = ~clk;

  bcd_serial_adder_ctrl #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .err(err), .busy(busy)
  );

  bcd_serial_adder_ctrl #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(1'b1),
    .sum(sum1), .cout(cout1), .err(err1), .busy(busy1)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    bit           chk;
    int           acc;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   bp_mode  = 0;  // 0: ready high, 1: random, 2: held low

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = int'(D) - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < int'(D); i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit any_bad(input logic [W-1:0] v);
    for (int i = 0; i < int'(D); i++) if (v[i*4 +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < int'(D); i++) r[i*4 +: 4] = 4'($urandom_range(9, 0));
    return r;
  endfunction

  // Present one operand pair, wait for acceptance, record the expected result
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    exp_t e;
    int   total, lim;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    cin = tc;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (in_ready) break;
      if (t > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    lim   = 1;
    for (int i = 0; i < int'(D); i++) lim = lim * 10;
    total = bcd2int(ta) + bcd2int(tb_v) + int'(tc);
    e.err  = any_bad(ta) | any_bad(tb_v);
    e.chk  = !e.err;
    e.sum  = int2bcd(total % lim);
    e.cout = (total >= lim);
    e.acc  = cyc + 1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic drain();
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !busy) break;
      if (t > 500) begin
        check("drain_timeout", 32'd0, 32'd1);
        sbq.delete();
        break;
      end
    end
  endtask

  task automatic check_reset_state();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_err", 32'(err), 32'd0);
  endtask

  // Consumer backpressure
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(2, 0) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pop and compare on each new result, then check it holds until taken
  bit           prev_ov = 1'b0;
  exp_t         cur;
  logic [W-1:0] h_sum;
  logic         h_cout, h_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready_in_done", 32'(in_ready), 32'd0);
        check("busy_in_done", 32'(busy), 32'd1);
        if (!prev_ov) begin
          if (sbq.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
          end else begin
            cur = sbq.pop_front();
            if (cur.chk) begin
              check("sum", 32'(sum), 32'(cur.sum));
              check("cout", 32'(cout), 32'(cur.cout));
            end
            check("err", 32'(err), 32'(cur.err));
            check("latency", 32'(cyc), 32'(cur.acc + int'(D)));
          end
          h_sum  = sum;
          h_cout = cout;
          h_err  = err;
        end else begin
          check("hold_sum", 32'(sum), 32'(h_sum));
          check("hold_cout", 32'(cout), 32'(h_cout));
          check("hold_err", 32'(err), 32'(h_err));
        end
      end else if (busy) begin
        check("in_ready_in_add", 32'(in_ready), 32'd0);
      end
      prev_ov = out_valid && !out_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    in_valid1 = 1'b0;
    a1 = '0;
    b1 = '0;
    cin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state();

    // Directed ops with consumer always ready
    issue(16'h1234, 16'h5678, 1'b0);
    issue(16'h9999, 16'h0001, 1'b0);
    issue(16'h9999, 16'h9999, 1'b1);
    issue(16'h0000, 16'h0000, 1'b0);
    drain();

    // Backpressure: result must hold while out_ready is low; junk in_valid ignored
    bp_mode = 2;
    issue(16'h4321, 16'h0789, 1'b1);
    for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    repeat (5) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = 16'h1111;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bp_mode = 0;
    drain();

    // Reset mid-ADD with a bad-digit op in flight: everything returns to reset values
    issue(16'h00A0, 16'h0001, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state();
    issue(16'h0458, 16'h0263, 1'b1);
    drain();

    // Invalid digit sets err; the next clean op clears it
    issue(16'h00A0, 16'h0001, 1'b0);
    issue(16'h1234, 16'h5678, 1'b0);
    drain();

    // Random ops under random backpressure, some with illegal digits
    bp_mode = 1;
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      ra = rand_bcd();
      rb = rand_bcd();
      if ($urandom_range(5, 0) == 0) ra[$urandom_range(D - 1, 0)*4 +: 4] = 4'($urandom_range(15, 10));
      issue(ra, rb, 1'($urandom));
      if ($urandom_range(2, 0) == 0) begin
        @(posedge clk);
        #1;
        if (!in_ready) begin
          in_valid = 1'b1;
          @(posedge clk);
          #1;
          in_valid = 1'b0;
        end
      end
    end
    drain();
    bp_mode = 0;

    // Single-digit build: 9 + 9 + 1 -> 9 carry 1, one cycle after accept
    @(negedge clk);
    check("d1_in_ready", 32'(in_ready1), 32'd1);
    @(posedge clk);
    #1;
    in_valid1 = 1'b1;
    a1 = 4'h9;
    b1 = 4'h9;
    cin1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    a1 = 4'h0;
    b1 = 4'h0;
    cin1 = 1'b0;
    @(negedge clk);
    check("d1_valid_early", 32'(out_valid1), 32'd0);
    @(negedge clk);
    check("d1_out_valid", 32'(out_valid1), 32'd1);
    check("d1_sum", 32'(sum1), 32'h9);
    check("d1_cout", 32'(cout1), 32'd1);
    check("d1_err", 32'(err1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
